// File: rtl/tail_lamp_monitor.sv
// rtl/tail_lamp_monitor.sv - receive-side sweep checker for the 6-bit tail-lamp LED bus
// Optional capture of the offending sample pair: define TAIL_LAMP_MON_CAPTURE_EN.
module tail_lamp_monitor #(
    parameter int LOCK_CNT   = 6,
    parameter int IDLE_LIMIT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             RST,
    input  logic             clk_slow,
    input  logic [5:0]       led,
    input  logic             fault_clr,
    output logic [1:0]       mode,
    output logic [1:0]       level,
    output logic             locked,
    output logic             step_err,
    output logic             mode_chg,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [ERR_W-1:0] err_count
`ifdef TAIL_LAMP_MON_CAPTURE_EN
    ,
    output logic [5:0]       cap_prev,
    output logic [5:0]       cap_cur
`endif
);

    typedef enum logic [1:0] {
        M_OFF   = 2'b00,
        M_LEFT  = 2'b01,
        M_RIGHT = 2'b10,
        M_HAZ   = 2'b11
    } mode_t;

    localparam int LOCK_W = $clog2(LOCK_CNT + 1);
    localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_LIMIT);

    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_SEQ     = 2'b10;

    // registered state
    mode_t             mode_q;
    logic [1:0]        prev_q;
    logic              dir_q;
    logic              dirk_q;
    logic [LOCK_W-1:0] lock_q;
    logic [IDLE_W-1:0] idle_q;

    // decode of the current sample
    mode_t             cls;
    logic [1:0]        lvl;
    logic              legal;

    // next-state values
    mode_t             mode_n;
    logic [1:0]        level_n;
    logic [1:0]        prev_n;
    logic              dir_n;
    logic              dirk_n;
    logic [LOCK_W-1:0] lock_n;
    logic [IDLE_W-1:0] idle_n;
    logic              seq_err;
    logic              chg;
    logic              clr_lock;
    logic              hz_ok;
    logic              err;
    logic [1:0]        code_n;

    always_comb begin
        cls   = M_OFF;
        lvl   = 2'd0;
        legal = 1'b1;
        case (led)
            6'b000000: begin cls = M_OFF;   lvl = 2'd0; end
            6'b100000: begin cls = M_LEFT;  lvl = 2'd1; end
            6'b110000: begin cls = M_LEFT;  lvl = 2'd2; end
            6'b111000: begin cls = M_LEFT;  lvl = 2'd3; end
            6'b000001: begin cls = M_RIGHT; lvl = 2'd1; end
            6'b000011: begin cls = M_RIGHT; lvl = 2'd2; end
            6'b000111: begin cls = M_RIGHT; lvl = 2'd3; end
            6'b100001: begin cls = M_HAZ;   lvl = 2'd1; end
            6'b110011: begin cls = M_HAZ;   lvl = 2'd2; end
            6'b111111: begin cls = M_HAZ;   lvl = 2'd3; end
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        mode_n   = mode_q;
        level_n  = level;
        prev_n   = prev_q;
        dir_n    = dir_q;
        dirk_n   = dirk_q;
        idle_n   = idle_q;
        seq_err  = 1'b0;
        chg      = 1'b0;
        clr_lock = 1'b0;
        hz_ok    = 1'b0;

        if (!legal) begin
            // illegal pattern leaves the tracked sweep untouched
            idle_n = '0;
        end else if (cls == M_OFF) begin
            level_n = 2'd0;
            prev_n  = 2'd0;
            if (idle_q != IDLE_MAX) begin
                idle_n = idle_q + IDLE_W'(1);
            end
            if (idle_n == IDLE_MAX) begin
                chg      = (mode_q != M_OFF);
                mode_n   = M_OFF;
                clr_lock = 1'b1;
            end
        end else begin
            idle_n  = '0;
            level_n = lvl;
            prev_n  = lvl;
            if (cls != mode_q) begin
                mode_n   = cls;
                chg      = 1'b1;
                clr_lock = 1'b1;
                if (cls == M_HAZ) begin
                    dirk_n = 1'b0;
                end
            end

            if (prev_q == 2'd0) begin
                // the sweep restarts from the first lamp after a blank
                if (lvl != 2'd1) begin
                    seq_err = 1'b1;
                end else if (cls == M_HAZ) begin
                    dir_n  = 1'b1;
                    dirk_n = 1'b1;
                end
            end else if (cls == mode_q) begin
                if (cls == M_HAZ) begin
                    if (prev_q == 2'd3) begin
                        hz_ok = (lvl == 2'd2);
                    end else if (dirk_q) begin
                        hz_ok = dir_q ? (lvl == prev_q + 2'd1) : (lvl == prev_q - 2'd1);
                    end else begin
                        hz_ok = (lvl == prev_q + 2'd1) || (lvl == prev_q - 2'd1);
                    end
                    if (hz_ok) begin
                        dir_n  = (lvl > prev_q);
                        dirk_n = 1'b1;
                    end else begin
                        seq_err = 1'b1;
                        dirk_n  = 1'b0;
                    end
                end else if ((prev_q == 2'd3) || (lvl != prev_q + 2'd1)) begin
                    seq_err = 1'b1;
                end
            end
        end
    end

    assign err    = !legal || seq_err;
    assign code_n = legal ? CODE_SEQ : CODE_ILLEGAL;

    always_comb begin
        lock_n = lock_q;
        if (err || clr_lock) begin
            lock_n = '0;
        end else if ((mode_n != M_OFF) && (lock_q != LOCK_MAX)) begin
            lock_n = lock_q + LOCK_W'(1);
        end
    end

    always_ff @(posedge clk_slow or posedge RST) begin
        if (RST) begin
            mode_q     <= M_OFF;
            prev_q     <= 2'd0;
            dir_q      <= 1'b0;
            dirk_q     <= 1'b0;
            lock_q     <= '0;
            idle_q     <= '0;
            level      <= 2'd0;
            locked     <= 1'b0;
            step_err   <= 1'b0;
            mode_chg   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            err_count  <= '0;
        end else begin
            mode_q   <= mode_n;
            prev_q   <= prev_n;
            dir_q    <= dir_n;
            dirk_q   <= dirk_n;
            lock_q   <= lock_n;
            idle_q   <= idle_n;
            level    <= level_n;
            locked   <= (lock_n == LOCK_MAX);
            step_err <= err;
            mode_chg <= chg;
            // a new error takes priority over a clear in the same sample
            if (err) begin
                fault      <= 1'b1;
                fault_code <= code_n;
            end else if (fault_clr) begin
                fault      <= 1'b0;
                fault_code <= 2'b00;
            end
            if (err && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    assign mode = mode_q;

`ifdef TAIL_LAMP_MON_CAPTURE_EN
    logic [5:0] led_q;

    always_ff @(posedge clk_slow or posedge RST) begin
        if (RST) begin
            led_q    <= 6'd0;
            cap_prev <= 6'd0;
            cap_cur  <= 6'd0;
        end else begin
            led_q <= led;
            if (err) begin
                cap_prev <= led_q;
                cap_cur  <= led;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tail_lamp_monitor.sv
// tb/tb_tail_lamp_monitor.sv - directed self-checking bench for tail_lamp_monitor
module tb_tail_lamp_monitor;

    logic       RST;
    logic       clk_slow;
    logic [5:0] led;
    logic       fault_clr;
    logic [1:0] mode;
    logic [1:0] level;
    logic       locked;
    logic       step_err;
    logic       mode_chg;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] err_count;
`ifdef TAIL_LAMP_MON_CAPTURE_EN
    logic [5:0] cap_prev;
    logic [5:0] cap_cur;
`endif

    int errors = 0;
    int checks = 0;

    tail_lamp_monitor #(.LOCK_CNT(6), .IDLE_LIMIT(2), .ERR_W(8)) dut (
        .RST        (RST),
        .clk_slow   (clk_slow),
        .led        (led),
        .fault_clr  (fault_clr),
        .mode       (mode),
        .level      (level),
        .locked     (locked),
        .step_err   (step_err),
        .mode_chg   (mode_chg),
        .fault      (fault),
        .fault_code (fault_code),
        .err_count  (err_count)
`ifdef TAIL_LAMP_MON_CAPTURE_EN
        ,
        .cap_prev   (cap_prev),
        .cap_cur    (cap_cur)
`endif
    );

    initial clk_slow = 1'b0;
    always #5 clk_slow = ~clk_slow;

    task automatic step(input logic [5:0] v, input logic c);
        led       = v;
        fault_clr = c;
        @(posedge clk_slow);
        #1;
    endtask

    task automatic do_reset;
        RST       = 1'b1;
        led       = 6'd0;
        fault_clr = 1'b0;
        @(posedge clk_slow);
        #1;
        RST = 1'b0;
    endtask

    task automatic left_to_lock;
        logic [5:0] pat [4];
        pat = '{6'b000000, 6'b100000, 6'b110000, 6'b111000};
        for (int n = 0; n < 8; n++) step(pat[n % 4], 1'b0);
    endtask

    task automatic test_reset;
        logic [17:0] obs;
        RST = 1'b1; led = 6'd0; fault_clr = 1'b0;
        @(posedge clk_slow); #1;
        obs = {mode, level, locked, step_err, mode_chg, fault, fault_code, err_count};
        checks++;
        if (obs !== 18'd0) begin errors++; $display("FAIL reset_state got=%h exp=0", obs); end
        RST = 1'b0;
        step(6'b100000, 1'b0);
        step(6'b101000, 1'b0);
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL rst_pre_err got=%0d exp=1", err_count); end
        #2 RST = 1'b1;
        #1;
        obs = {mode, level, locked, step_err, mode_chg, fault, fault_code, err_count};
        checks++;
        if (obs !== 18'd0) begin errors++; $display("FAIL rst_async got=%h exp=0", obs); end
        #1 RST = 1'b0;
        step(6'b000000, 1'b0);
        obs = {mode, level, locked, step_err, mode_chg, fault, fault_code, err_count};
        checks++;
        if (obs !== 18'd0) begin errors++; $display("FAIL rst_next_sample got=%h exp=0", obs); end
        step(6'b110000, 1'b0);
        checks++;
        if ({step_err, fault_code} !== 3'b110) begin
            errors++; $display("FAIL rst_first_level got=%b exp=110", {step_err, fault_code});
        end
    endtask

    task automatic test_left_sweep;
        logic [5:0] pat [4];
        logic [6:0] exp_v;
        int n;
        pat = '{6'b000000, 6'b100000, 6'b110000, 6'b111000};
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                n = r * 4 + i;
                step(pat[i], 1'b0);
                exp_v = {(n == 0) ? 2'b00 : 2'b01, 2'(i), (n >= 7), 1'b0, (n == 1)};
                checks++;
                if ({mode, level, locked, step_err, mode_chg} !== exp_v) begin
                    errors++;
                    $display("FAIL left_sweep[%0d] mode/level/locked/err/chg got=%b exp=%b", n,
                             {mode, level, locked, step_err, mode_chg}, exp_v);
                end
            end
        end
        checks++;
        if ({fault, err_count} !== 9'd0) begin
            errors++; $display("FAIL left_no_fault got=%h exp=0", {fault, err_count});
        end
    endtask

    task automatic test_hazard;
        logic [5:0] pat [8];
        logic [1:0] lv [8];
        logic [4:0] exp_v;
        pat = '{6'b000000, 6'b100001, 6'b110011, 6'b111111,
                6'b110011, 6'b100001, 6'b000000, 6'b100001};
        lv  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        do_reset();
        for (int n = 0; n < 8; n++) begin
            step(pat[n], 1'b0);
            exp_v = {(n == 0) ? 2'b00 : 2'b11, lv[n], 1'b0};
            checks++;
            if ({mode, level, step_err} !== exp_v) begin
                errors++;
                $display("FAIL hazard[%0d] mode/level/err got=%b exp=%b", n, {mode, level, step_err}, exp_v);
            end
        end
        step(6'b110011, 1'b0);
        step(6'b111111, 1'b0);
        checks++;
        if ({step_err, level} !== 3'b011) begin
            errors++; $display("FAIL hazard_up got=%b exp=011", {step_err, level});
        end
        step(6'b111111, 1'b0);
        checks++;
        if ({step_err, fault, fault_code, mode} !== 6'b111011) begin
            errors++; $display("FAIL hazard_repeat got=%b exp=111011", {step_err, fault, fault_code, mode});
        end
    endtask

    task automatic test_illegal;
        do_reset();
        step(6'b000000, 1'b0);
        step(6'b000001, 1'b0);
        step(6'b000011, 1'b0);
        step(6'b000111, 1'b0);
        checks++;
        if ({mode, level, step_err} !== 5'b10110) begin
            errors++; $display("FAIL right_sweep got=%b exp=10110", {mode, level, step_err});
        end
        step(6'b101000, 1'b0);
        checks++;
        if ({step_err, fault, fault_code, err_count, mode, level} !== 16'b1_1_01_00000001_10_11) begin
            errors++;
            $display("FAIL illegal_pat got=%b exp=%b", {step_err, fault, fault_code, err_count, mode, level},
                     16'b1_1_01_00000001_10_11);
        end
        step(6'b000000, 1'b0);
        checks++;
        if ({step_err, fault, err_count, mode, level} !== 14'b0_1_00000001_10_00) begin
            errors++;
            $display("FAIL illegal_after got=%b exp=%b", {step_err, fault, err_count, mode, level},
                     14'b0_1_00000001_10_00);
        end
    endtask

    task automatic test_fault_clr;
        do_reset();
        left_to_lock();
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL clr_locked got=%b exp=1", locked); end
        step(6'b000000, 1'b0);
        step(6'b100000, 1'b0);
        step(6'b111000, 1'b0);
        checks++;
        if ({step_err, fault_code, locked, err_count} !== 12'b1_10_0_00000001) begin
            errors++;
            $display("FAIL skip_level got=%b exp=%b", {step_err, fault_code, locked, err_count},
                     12'b1_10_0_00000001);
        end
        step(6'b000000, 1'b1);
        checks++;
        if ({fault, fault_code, step_err} !== 4'b0000) begin
            errors++; $display("FAIL fault_clr got=%b exp=0000", {fault, fault_code, step_err});
        end
        step(6'b101010, 1'b1);
        checks++;
        if ({fault, fault_code, err_count} !== 11'b1_01_00000010) begin
            errors++; $display("FAIL clr_vs_err got=%b exp=%b", {fault, fault_code, err_count}, 11'b1_01_00000010);
        end
    endtask

    task automatic test_idle;
        do_reset();
        left_to_lock();
        step(6'b000000, 1'b0);
        checks++;
        if ({mode, locked, mode_chg} !== 4'b0110) begin
            errors++; $display("FAIL idle_one got=%b exp=0110", {mode, locked, mode_chg});
        end
        step(6'b000000, 1'b0);
        checks++;
        if ({mode, locked, mode_chg, step_err} !== 5'b00010) begin
            errors++; $display("FAIL idle_limit got=%b exp=00010", {mode, locked, mode_chg, step_err});
        end
        step(6'b000011, 1'b0);
        checks++;
        if ({step_err, fault_code} !== 3'b110) begin
            errors++; $display("FAIL level2_after_blank got=%b exp=110", {step_err, fault_code});
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        step(6'b000000, 1'b0);
        step(6'b100000, 1'b0);
        step(6'b110000, 1'b0);
        step(6'b110011, 1'b0);
        checks++;
        if ({mode, level, mode_chg, step_err} !== 6'b111010) begin
            errors++; $display("FAIL enter_hazard got=%b exp=111010", {mode, level, mode_chg, step_err});
        end
        step(6'b100001, 1'b0);
        checks++;
        if ({level, step_err, mode_chg} !== 4'b0100) begin
            errors++; $display("FAIL hazard_free_dir got=%b exp=0100", {level, step_err, mode_chg});
        end
        step(6'b110011, 1'b0);
        checks++;
        if ({step_err, fault_code} !== 3'b110) begin
            errors++; $display("FAIL hazard_dir_down got=%b exp=110", {step_err, fault_code});
        end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int i = 0; i < 260; i++) step(6'b010101, 1'b0);
        checks++;
        if ({err_count, fault, step_err} !== 10'b11111111_1_1) begin
            errors++; $display("FAIL err_saturate got=%b exp=1111111111", {err_count, fault, step_err});
        end
    endtask

    initial begin
        RST       = 1'b1;
        led       = 6'd0;
        fault_clr = 1'b0;
        test_reset();
        test_left_sweep();
        test_hazard();
        test_illegal();
        test_fault_clr();
        test_idle();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tail_lamp_monitor.md
Name: tail_lamp_monitor

Overview:
- Receive-side checker for the 6-bit tail-lamp LED bus (bits [5:3] left bar, [2:0] right bar) driven by the turn-indicator controller.
- Samples the bus on every clk_slow edge, decodes the active mode (off/left/right/hazard) and the sweep level, and checks each step against the legal sweep rules.
- Reports step errors, a sticky fault with a cause code, and a lock indication. Used for on-board self-test and for bench scoreboarding of the controller.

Parameters:
- LOCK_CNT, 6: consecutive legal samples in a non-OFF mode before `locked` asserts.
- IDLE_LIMIT, 2: consecutive blank samples that force mode OFF.
- ERR_W, 8: width of the saturating error counter.

Ports:
- RST  input  1  asynchronous reset, active-high.
- clk_slow  input  1  sweep clock; every rising edge is one sample.
- led  input  6  observed lamp bus.
- fault_clr  input  1  synchronous clear of the sticky fault.
- mode  output  2  00 OFF, 01 LEFT, 10 RIGHT, 11 HAZARD.
- level  output  2  lit lamps per side in the current sample, 0..3.
- locked  output  1  sweep tracked cleanly for LOCK_CNT samples.
- step_err  output  1  one-sample pulse on any violation.
- mode_chg  output  1  one-sample pulse when mode changes.
- fault  output  1  sticky error flag.
- fault_code  output  2  cause of the most recent error: 01 illegal pattern, 10 sequence error.
- err_count  output  ERR_W  saturating count of errors.

Behaviour:
- Reset: all outputs 0. Internal state cleared: prev level 0, dir_known 0, lock/idle counters 0.
- All outputs are registered. They reflect the sample taken at the same edge (1-edge latency from led to outputs).
- Legal patterns (10 total):
  - Blank: 000000.
  - LEFT: 100000, 110000, 111000 (levels 1-3).
  - RIGHT: 000001, 000011, 000111 (levels 1-3).
  - HAZARD: 100001, 110011, 111111 (levels 1-3).
- Illegal pattern: any other value → step_err, fault_code=01. mode, level and prev are unchanged.
- Blank sample:
  - Always legal; level=0 and prev level becomes 0.
  - mode holds its value. idle_cnt increments; at IDLE_LIMIT, mode→00, locked→0, lock_cnt→0, and mode_chg pulses if mode was non-OFF.
- Any non-blank sample clears idle_cnt.
- Non-blank after blank: new level must be 1, otherwise sequence error (fault_code=10). If the class differs from mode, mode updates and mode_chg pulses.
- Non-blank with a different class than the previous non-blank sample:
  - Legal mode change: mode updates, mode_chg pulses, lock_cnt→0, no step check.
  - Entering HAZARD clears dir_known.
- LEFT/RIGHT, same class: from level P in {1,2}, next must be P+1. From level 3 only blank is legal. A repeated identical pattern is a sequence error.
- HAZARD, same class (P = previous level, N = new level):
  - P=3 → N=2.
  - P in {1,2} with dir_known → N=P+1 if dir is up, N=P−1 if dir is down.
  - P in {1,2} without dir_known → N=P±1 accepted.
  - After every legal hazard step: dir=(N>P), dir_known=1.
  - Resulting legal cycle: 0,1,2,3,2,1,0,1...
- lock_cnt: increments on each legal sample while mode≠OFF. locked=1 once lock_cnt reaches LOCK_CNT; the counter saturates there. Any error clears lock_cnt and locked.
- Any error: step_err=1 for one sample, fault=1, fault_code updated, err_count+1 (saturates at all-ones).
- fault_clr: clears fault and fault_code. If an error occurs in the same sample, the error wins.
- RST mid-sweep: immediate return to the reset state. The first post-reset non-blank sample must be level 1.

Optional Feature:
- Macro: TAIL_LAMP_MON_CAPTURE_EN.
- Defined: adds outputs cap_prev[5:0] and cap_cur[5:0]. They hold the previous and offending led samples of the most recent error, are updated on every error, and are cleared by RST (not by fault_clr).
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- RST pulse mid-operation → all outputs 0 on the next sample; err_count=0.
- Left sweep 000000,100000,110000,111000 repeated 3 times → mode=01, level 0,1,2,3 tracked, mode_chg once, locked=1 after the 6th legal sample, step_err never asserted.
- Hazard stream 000000,100001,110011,111111,110011,100001,000000,100001 → mode=11, no errors. Then inject 110011→111111→111111 → step_err, fault_code=10.
- Right sweep, then 101000 → step_err pulse, fault=1, fault_code=01, err_count=1, mode stays 10.
- Left 100000→111000 → fault_code=10, locked→0. Assert fault_clr with no error → fault=0; assert fault_clr together with a new error → fault stays 1.
- After locked left sweep, hold 000000 for 2 samples → mode=00, mode_chg pulse, locked=0. Then 000011 → sequence error (level 2 after blank).
